// File: rtl/pe_link_rx.sv
// rtl/pe_link_rx.sv - overlay link receive endpoint: link decode, framing, FWFT FIFO, credit return
// Optional PE_LINK_RX_STATS_EN adds pkt_count/word_count outputs.
module pe_link_rx #(
   parameter int LINK_WIDTH     = 130,
   parameter int FIFO_ADDR_BITS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ap_start,
   input  logic [LINK_WIDTH-1:0]     in_from_west,
   output logic [LINK_WIDTH-1:0]     out_to_west,
   output logic [LINK_WIDTH-3:0]     m_data,
   output logic                      m_last,
   output logic                      m_first,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [FIFO_ADDR_BITS:0]   fifo_count,
   output logic                      overflow
`ifdef PE_LINK_RX_STATS_EN
   ,
   output logic [31:0]               pkt_count,
   output logic [31:0]               word_count
`endif
);

   localparam int DATA_WIDTH = LINK_WIDTH - 2;
   localparam int DEPTH      = 1 << FIFO_ADDR_BITS;
   localparam logic [FIFO_ADDR_BITS:0] FULL_COUNT = (FIFO_ADDR_BITS+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_PKT} frame_state_t;

   frame_state_t                state;
   logic [DATA_WIDTH-1:0]       mem_data [DEPTH];
   logic [DEPTH-1:0]            mem_last;
   logic [DEPTH-1:0]            mem_first;
   logic [FIFO_ADDR_BITS-1:0]   wr_ptr;
   logic [FIFO_ADDR_BITS-1:0]   rd_ptr;
   logic [FIFO_ADDR_BITS:0]     count;
   logic                        credit;

   logic                        word_valid;
   logic                        word_last;
   logic [DATA_WIDTH-1:0]       word_data;
   logic                        empty;
   logic                        full;
   logic                        push;
   logic                        pop;

   assign word_valid = in_from_west[LINK_WIDTH-1];
   assign word_last  = in_from_west[LINK_WIDTH-2];
   assign word_data  = in_from_west[LINK_WIDTH-3:0];

   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);
   assign pop   = m_valid & m_ready;
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign push  = word_valid & (~full | pop);

   assign m_valid     = ~empty & ap_start;
   assign m_data      = empty ? '0 : mem_data[rd_ptr];
   assign m_last      = ~empty & mem_last[rd_ptr];
   assign m_first     = ~empty & mem_first[rd_ptr];
   assign fifo_count  = count;
   assign out_to_west = {{(LINK_WIDTH-1){1'b0}}, credit};

   // Storage needs no reset: reads are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr]  <= word_data;
         mem_last[wr_ptr]  <= word_last;
         mem_first[wr_ptr] <= (state == S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         credit   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         credit <= pop;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            case (state)
               S_IDLE:  state <= word_last ? S_IDLE : S_PKT;
               S_PKT:   state <= word_last ? S_IDLE : S_PKT;
               default: state <= S_IDLE;
            endcase
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (word_valid & full & ~pop)
            overflow <= 1'b1;
      end
   end

`ifdef PE_LINK_RX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count  <= '0;
         word_count <= '0;
      end else if (pop) begin
         word_count <= word_count + 1'b1;
         if (m_last)
            pkt_count <= pkt_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_link_rx.sv
// tb/tb_pe_link_rx.sv - randomized self-checking bench for pe_link_rx against a queue model
module tb_pe_link_rx;

   localparam int LW    = 130;
   localparam int DW    = LW - 2;
   localparam int DEPTH = 16;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           ap_start = 1'b0;
   logic [LW-1:0]  in_from_west = '0;
   logic [LW-1:0]  out_to_west;
   logic [DW-1:0]  m_data;
   logic           m_last, m_first, m_valid;
   logic           m_ready = 1'b0;
   logic [4:0]     fifo_count;
   logic           overflow;
`ifdef PE_LINK_RX_STATS_EN
   logic [31:0]    pkt_count, word_count;
   logic [31:0]    exp_pkts, exp_words;
`endif

   pe_link_rx #(.LINK_WIDTH(LW), .FIFO_ADDR_BITS(4)) dut (
      .clk(clk), .reset(reset), .ap_start(ap_start), .in_from_west(in_from_west),
      .out_to_west(out_to_west), .m_data(m_data), .m_last(m_last), .m_first(m_first),
      .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count), .overflow(overflow)
`ifdef PE_LINK_RX_STATS_EN
      , .pkt_count(pkt_count), .word_count(word_count)
`endif
   );

   always #5 clk = ~clk;

   // Model entry: {first, last, data}
   logic [DW+1:0] q[$];
   logic          in_pkt;
   logic          exp_ovf;
   logic          exp_credit;
   int            n_checks = 0;
   int            n_pass = 0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_clear();
      q.delete();
      in_pkt = 1'b0;
      exp_ovf = 1'b0;
      exp_credit = 1'b0;
`ifdef PE_LINK_RX_STATS_EN
      exp_pkts = '0;
      exp_words = '0;
`endif
   endtask

   // One clock: drive inputs, compare outputs against the model, then advance the model.
   task automatic cycle(input logic v, input logic l, input logic [DW-1:0] d,
                        input logic ap, input logic rdy, input logic rst);
      logic      exp_valid;
      logic      do_pop;
      @(negedge clk);
      reset = rst;
      ap_start = ap;
      m_ready = rdy;
      in_from_west = {v, l, d};
      #1;
      exp_valid = (q.size() != 0) && ap;
      check("m_valid", LW'(m_valid), LW'(exp_valid));
      check("fifo_count", LW'(fifo_count), LW'(q.size()));
      check("overflow", LW'(overflow), LW'(exp_ovf));
      check("credit", out_to_west, LW'(exp_credit));
      if (q.size() != 0) begin
         check("m_data", LW'(m_data), LW'(q[0][DW-1:0]));
         check("m_last", LW'(m_last), LW'(q[0][DW]));
         check("m_first", LW'(m_first), LW'(q[0][DW+1]));
      end
`ifdef PE_LINK_RX_STATS_EN
      check("word_count", LW'(word_count), LW'(exp_words));
      check("pkt_count", LW'(pkt_count), LW'(exp_pkts));
`endif
      if (rst) begin
         model_clear();
      end else begin
         do_pop = exp_valid && rdy;
         exp_credit = do_pop;
         if (v) begin
            if (q.size() < DEPTH || do_pop) begin
               q.push_back({~in_pkt, l, d});
               in_pkt = ~l;
            end else begin
               exp_ovf = 1'b1;
            end
         end
         if (do_pop) begin
`ifdef PE_LINK_RX_STATS_EN
            exp_words++;
            if (q[0][DW]) exp_pkts++;
`endif
            void'(q.pop_front());
         end
      end
   endtask

   task automatic idle(input int n, input logic ap, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, ap, rdy, 1'b0);
   endtask

   initial begin
      model_clear();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_m_data", LW'(m_data), '0);
      check("reset_first_last", LW'({m_first, m_last}), '0);

      // Three-word packet streamed straight through
      cycle(1'b1, 1'b0, rand_data(), 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, rand_data(), 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, rand_data(), 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1, 1'b1);

      // Fill while held, then drain
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, (i % 4) == 3, rand_data(), 1'b0, 1'b1, 1'b0);
      idle(2, 1'b0, 1'b1);
      idle(DEPTH + 3, 1'b1, 1'b1);

      // Full, overflow, then simultaneous push and pop at full
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, rand_data(), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, rand_data(), 1'b1, 1'b0, 1'b0);
      idle(1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, rand_data(), 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, rand_data(), 1'b1, 1'b1, 1'b0);
      idle(DEPTH + 2, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Single-word packets back to back, with and without full-through pops
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, rand_data(), 1'b1, i[0], 1'b0);
      idle(8, 1'b1, 1'b1);

      // Reset mid-packet with five words buffered
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, rand_data(), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, rand_data(), 1'b1, 1'b0, 1'b0);
      idle(3, 1'b1, 1'b1);

      // Randomized phases with varying pressure
      for (int ph = 0; ph < 8; ph++) begin
         int pv, pa, pr;
         pv = $urandom_range(10, 95);
         pa = $urandom_range(30, 100);
         pr = $urandom_range(10, 95);
         for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < pv, $urandom_range(0, 3) == 0, rand_data(),
                  $urandom_range(0, 99) < pa, $urandom_range(0, 99) < pr,
                  $urandom_range(0, 299) == 0);
         end
      end
      idle(DEPTH + 2, 1'b1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
